// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding, glyph patterns and width helper for the segment scanner
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// rtl/seg_glyph_rom.sv - combinational 4-bit code to active-low seven-segment pattern
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_BLANK;
        case (code_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            default: seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scanner with blanking gap and per-digit blink
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 50000000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [31:0] string_i,
    input  logic [7:0]  blink_mask_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_done_o
);

    localparam int unsigned TW = cnt_width((DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES);
    localparam int unsigned BW = cnt_width(BLINK_DIV);
    localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [31:0]   shadow_q;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          frame_done_q;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    logic [6:0]    rom_seg;
    logic [6:0]    lit_seg;
    logic [7:0]    lit_an;

    seg_glyph_rom u_glyph_rom (
        .code_i (shadow_q[{idx_q, 2'b00} +: 4]),
        .seg_o  (rom_seg)
    );

    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Blink gating uses the phase this edge produces so segments and phase stay aligned.
    assign lit_seg = (blink_mask_i[idx_q] && !blink_phase_d) ? GLYPH_BLANK : rom_seg;
    assign lit_an  = ~(8'h01 << idx_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= 32'hFFFF_FFFF;
            an_q         <= 8'hFF;
            seg_q        <= GLYPH_BLANK;
            frame_done_q <= 1'b0;
        end else if (!enable_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            an_q         <= 8'hFF;
            seg_q        <= GLYPH_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_BLANK;
                    timer_q  <= '0;
                    idx_q    <= '0;
                    shadow_q <= string_i;
                    an_q     <= 8'hFF;
                    seg_q    <= GLYPH_BLANK;
                end
                ST_BLANK: begin
                    if (timer_q == BLANK_LAST) begin
                        state_q <= ST_DRIVE;
                        timer_q <= '0;
                        an_q    <= lit_an;
                        seg_q   <= lit_seg;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (timer_q == DIGIT_LAST) begin
                        state_q <= ST_BLANK;
                        timer_q <= '0;
                        idx_q   <= idx_q + 3'd1;
                        an_q    <= 8'hFF;
                        seg_q   <= GLYPH_BLANK;
                        // Frame boundary: report and latch the next string on the same edge.
                        if (idx_q == 3'd7) begin
                            frame_done_q <= 1'b1;
                            shadow_q     <= string_i;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        seg_q   <= lit_seg;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    idx_q   <= '0;
                    an_q    <= 8'hFF;
                    seg_q   <= GLYPH_BLANK;
                end
            endcase
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = 1'b1;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized directed bench for seg_scan_driver against a frame-timing model
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int B  = 1;
    localparam int BD = 8;
    localparam int P  = B + D;
    localparam int F  = 8 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] str = 32'h0;
    logic [7:0]  mask = 8'h00;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;

    int checks = 0;
    int errors = 0;

    int          edge_k = 0;
    int          t = 0;
    bit          active = 1'b0;
    logic [31:0] shadow_m = 32'hFFFF_FFFF;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

    seg_scan_driver #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B),
        .BLINK_DIV    (BD)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .enable_i     (en),
        .string_i     (str),
        .blink_mask_i (mask),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .frame_done_o (fd)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lit();
        return active && ((t % F) % P) >= B;
    endfunction

    function automatic int model_digit();
        return (t % F) / P;
    endfunction

    task automatic step();
        bit          en_s = en;
        logic [31:0] str_s = str;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_fd;
        bit          phase;
        int          dig;
        @(posedge clk);
        if (rst) begin
            edge_k = 0;
            active = 1'b0;
        end else begin
            edge_k++;
            if (!en_s) begin
                active = 1'b0;
            end else if (!active) begin
                active   = 1'b1;
                t        = 0;
                shadow_m = str_s;
            end else begin
                t++;
                if (t % F == 0) shadow_m = str_s;
            end
        end
        #1;
        phase   = ((edge_k / BD) % 2) == 0;
        dig     = model_digit();
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        if (model_lit()) begin
            exp_an  = ~(8'h01 << dig);
            exp_seg = (mask[dig] && !phase) ? 7'h7F : glyph_tab[shadow_m[dig*4 +: 4]];
        end
        exp_fd = active && (t > 0) && (t % F == 0);
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("frame_done", 32'(fd), 32'(exp_fd));
        check("dp", 32'(dp), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_digit(input int dig, input string tag);
        int budget = 200;
        while (!(model_lit() && model_digit() == dig) && budget > 0) begin
            step();
            budget--;
        end
        check(tag, 32'(budget > 0), 32'd1);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_fd", 32'(fd), 32'd0);
        run(2);
        #2 rst = 1'b0;

        str = 32'h7654_3210;
        en  = 1'b1;
        run(85);

        wait_digit(3, "reach_digit3");
        str = 32'hFFFF_FFFF;
        run(60);

        str  = $urandom;
        mask = 8'h01;
        run(100);
        mask = 8'h00;

        str = 32'hFEDC_BA98;
        run(45);

        wait_digit(5, "reach_digit5");
        en = 1'b0;
        step();
        str = $urandom;
        en  = 1'b1;
        run(50);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(39, 0) == 0) str = $urandom;
            if ($urandom_range(29, 0) == 0) mask = 8'($urandom);
            if ($urandom_range(59, 0) == 0) en = 1'b0;
            else en = 1'b1;
            step();
        end
        en = 1'b1;
        run(3);

        wait_digit($urandom_range(7, 0), "reach_random_digit");
        #2 rst = 1'b1;
        #1;
        check("async_reset_an", 32'(an), 32'hFF);
        check("async_reset_seg", 32'(seg), 32'h7F);
        check("async_reset_fd", 32'(fd), 32'd0);
        #1 rst = 1'b0;
        edge_k = 0;
        active = 1'b0;
        mask = 8'($urandom);
        str  = $urandom;
        run(90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
